// File: rtl/module_suma_pkg.sv
// Shared types and constants for the suma initiator: FSM encoding, index width, sum width helper.
package module_suma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam int IDX_W = 8;

  // Three WIDTH-bit operands need two extra bits so the sum can never overflow.
  function automatic int sum_w(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/module_suma_fifo.sv
// Synchronous FIFO with registered occupancy count; push is refused while full, pop ignored while empty.
module module_suma_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the registered count only, so a pop never frees a slot in the same cycle.
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/module_suma_driver.sv
// Initiator for the 3-operand suma adder: buffers operand triples, drives them, samples the sum after a settle window.
// Optional SUMA_CHECK_EN adds a reference-sum comparison with sticky err_o and saturating err_cnt_o.
module module_suma_driver
  import module_suma_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [WIDTH-1:0]          in_b,
  input  logic [WIDTH-1:0]          in_c,
  output logic [WIDTH-1:0]          a_o,
  output logic [WIDTH-1:0]          b_o,
  output logic [WIDTH-1:0]          c_o,
  input  logic [sum_w(WIDTH)-1:0]   suma_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [sum_w(WIDTH)-1:0]   out_sum,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      busy,
  output logic [1:0]                dbg_state
`ifdef SUMA_CHECK_EN
  ,
  output logic                      err_o,
  output logic [7:0]                err_cnt_o
`endif
);

  localparam int SW = sum_w(WIDTH);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYC - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a valid source
  // keeps its payload stable until that edge, and ready never depends on valid.

  state_t              state;
  logic [CW-1:0]       wait_cnt;
  logic [3*WIDTH-1:0]  fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                capture;

  assign pop       = (state == DRIVE);
  assign capture   = (state == WAIT) && (wait_cnt == LAST);
  assign in_ready  = !fifo_full;
  assign dbg_state = state;

  module_suma_fifo #(
    .DW    (3*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata ({in_a, in_b, in_c}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      a_o       <= '0;
      b_o       <= '0;
      c_o       <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= DRIVE;
            busy  <= 1'b1;
          end
        end
        DRIVE: begin
          {a_o, b_o, c_o} <= fifo_rdata;
          wait_cnt        <= '0;
          state           <= WAIT;
        end
        WAIT: begin
          if (capture) begin
            out_sum   <= suma_i;
            out_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESULT: begin
          // The index advances only on delivery, so a dropped transaction never consumes one.
          if (out_ready) begin
            out_valid <= 1'b0;
            out_idx   <= out_idx + IDX_W'(1);
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SUMA_CHECK_EN
  logic [SW-1:0] ref_sum;

  assign ref_sum = SW'(a_o) + SW'(b_o) + SW'(c_o);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else if (capture && (suma_i != ref_sum)) begin
      err_o <= 1'b1;
      if (err_cnt_o != 8'hFF) begin
        err_cnt_o <= err_cnt_o + 8'd1;
      end
    end
  end
`endif

endmodule
